vga_timing_gen: RTL
===================

# vga_timing_gen

Generates VGA raster timing for the display pipeline. It divides the system clock into a pixel-rate enable and runs the horizontal and vertical counters. From those counters it produces the sync, blanking and frame/line markers. Its `hcount`/`vcount` outputs drive the pixel-fetch stage directly, and its sync outputs go to the connector.

## Interface
- `H_VISIBLE`, default 640: visible pixels per line
- `H_FP`, default 16: horizontal front porch, in pixels
- `H_SYNC`, default 96: horizontal sync width, in pixels
- `H_BP`, default 48: horizontal back porch, in pixels
- `V_VISIBLE`, default 480: visible lines per frame
- `V_FP`, default 10: vertical front porch, in lines
- `V_SYNC`, default 2: vertical sync width, in lines
- `V_BP`, default 33: vertical back porch, in lines
- `CLK_DIV`, default 2: clk cycles per pixel, must be ≥1
- `SYNC_POL`, default 0: active level of hsync/vsync (0 = active-low)
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  run enable; when low, all state holds
- `hcount`  out  11  current pixel column, 0..H_TOTAL-1
- `vcount`  out  10  current line, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, polarity set by SYNC_POL
- `vsync`  out  1  vertical sync, polarity set by SYNC_POL
- `blank`  out  1  high outside the visible area
- `pix_en`  out  1  one-clk pulse; high in the first clk of each new pixel
- `line_start`  out  1  one-clk pulse when hcount becomes 0
- `frame_start`  out  1  one-clk pulse when (hcount,vcount) becomes (0,0)

## Operation
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Divider `div` counts 0..CLK_DIV-1 while `en`=1.
- Internal tick = `en` && `div`==CLK_DIV-1.
- On a tick, `div` returns to 0. With CLK_DIV=1, every `en` cycle is a tick.
- On a tick, `hcount` increments. At H_TOTAL-1 it wraps to 0 and `vcount` increments.
- `vcount` wraps V_TOTAL-1 → 0 on the same tick that `hcount` wraps.
- Horizontal region, decoded from `hcount`: ACTIVE [0, H_VISIBLE-1] → FRONT → SYNC [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] → BACK → ACTIVE.
- With defaults, horizontal SYNC spans hcount 656..751.
- Vertical region, decoded the same way from `vcount`. With defaults, vertical SYNC spans vcount 490..491.
- `hsync` is active iff the horizontal region is SYNC. `vsync` is active iff the vertical region is SYNC.
- `blank` = (hcount ≥ H_VISIBLE) || (vcount ≥ V_VISIBLE).
- All outputs are registered. The registers are loaded from next-state values, so `hsync`/`vsync`/`blank` always describe the `hcount`/`vcount` presented in the same cycle.
- `pix_en`, `line_start` and `frame_start` are set only on a tick, and only for that one clk.
- `line_start` is set on a tick whose new hcount is 0. `frame_start` is set on a tick whose new count is (0,0). When `frame_start` is high, `line_start` is also high.
- `en` low: `div`, the counters and the level outputs hold. The pulse outputs go 0 on the next clk.
- When `en` returns high, the divider resumes from its held value. No pixel is skipped or repeated.
- Counter arithmetic is unsigned. Counts never exceed TOTAL-1.

## Timing
- Reset (any cycle, including mid-line or mid-sync): values on the next clk edge are
  - `div`=0, `hcount`=0, `vcount`=0
  - `hsync`=`vsync`=inactive (1 when SYNC_POL=0)
  - `blank`=0
  - `pix_en`=`line_start`=`frame_start`=0
- No `frame_start` pulse is generated by the reset itself. The first pulse comes at the first wrap.
- `rst` has priority over `en`.
- Latency: counters change on the clk edge that ends a tick cycle. `pix_en` is high in the cycle the new count is first visible.
- Pixel period: exactly CLK_DIV clk cycles while `en`=1.
- Line period: H_TOTAL·CLK_DIV clks. Frame period: H_TOTAL·V_TOTAL·CLK_DIV clks (840000 with defaults).
- Downstream stages that register a pixel from `hcount`/`vcount` add their own latency. Those stages must delay hsync/vsync/blank by a matching amount.

## Test plan
- Reset values: hold `rst`=1 for 3 clks with `en`=1, then release.
  - Required: hcount=0, vcount=0, hsync=vsync=1, blank=0, all pulses 0.
  - Required: first pix_en 2 clks after release, with hcount=1.
- Horizontal sequence, defaults, `en`=1:
  - hsync falls when hcount becomes 656 and rises when hcount becomes 752.
  - blank rises at hcount 640.
  - hcount 799 → 0 with vcount +1 and line_start=1.
  - Each pixel lasts exactly 2 clks.
- Frame wrap: run to (799,524) and step one tick.
  - Required: (0,0), frame_start=1, line_start=1, blank=0.
  - Required: vsync active exactly while vcount is 490..491.
  - Required: frame_start pulses are 840000 clks apart.
- Enable hold: drop `en` for 7 clks at hcount=655, div=1.
  - Required: no count, sync or blank change during the hold; pulses 0.
  - Required: on re-enable, hcount becomes 656 and hsync falls after exactly 1 clk.
- Reset mid-sync: assert `rst` for 1 clk at (700,491), inside both sync pulses.
  - Required: next cycle shows (0,0) with both syncs inactive and no frame_start.
- CLK_DIV=1, SYNC_POL=1:
  - Required: counters advance every clk; syncs are active-high; frame period is 420000 clks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A clock divider produces the pixel-rate tick. The tick advances the
// horizontal and vertical counters. Sync, blank and the start-of-line/frame
// markers are decoded from the next-state counts and registered together
// with the counts, so every output describes the hcount/vcount presented
// in the same cycle.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter int SYNC_POL  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        pix_en,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // A one-bit divider is kept for CLK_DIV=1; it simply stays at 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  // Region boundaries: *_FP_BEG is the first non-visible count,
  // *_SYNC_BEG the first sync count, *_BP_BEG the first back-porch count.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FP_BEG   = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_BP_BEG   = 11'(H_VISIBLE + H_FP + H_SYNC);

  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_FP_BEG   = 10'(V_VISIBLE);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  V_BP_BEG   = 10'(V_VISIBLE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = (SYNC_POL == 0);

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FRONT,
    REG_SYNC,
    REG_BACK
  } region_t;

  function automatic region_t h_region(input logic [10:0] c);
    if (c < H_FP_BEG)        return REG_ACTIVE;
    else if (c < H_SYNC_BEG) return REG_FRONT;
    else if (c < H_BP_BEG)   return REG_SYNC;
    else                     return REG_BACK;
  endfunction

  function automatic region_t v_region(input logic [9:0] c);
    if (c < V_FP_BEG)        return REG_ACTIVE;
    else if (c < V_SYNC_BEG) return REG_FRONT;
    else if (c < V_BP_BEG)   return REG_SYNC;
    else                     return REG_BACK;
  endfunction

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic [10:0]      h_nxt;
  logic [9:0]       v_nxt;
  region_t          h_reg_nxt;
  region_t          v_reg_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             blank_nxt;

  // Divider and counter next-state; everything holds while en is low.
  always_comb begin
    tick    = 1'b0;
    div_nxt = div;
    h_nxt   = hcount;
    v_nxt   = vcount;
    h_wrap  = (hcount == H_LAST);
    v_wrap  = (vcount == V_LAST);
    if (en) begin
      if (div == DIV_LAST) begin
        tick    = 1'b1;
        div_nxt = '0;
      end else begin
        div_nxt = div + DIV_ONE;
      end
    end
    if (tick) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? 10'd0 : vcount + 10'd1;
      end else begin
        h_nxt = hcount + 11'd1;
      end
    end
  end

  // Level outputs decoded from the counts that will be shown next cycle.
  always_comb begin
    h_reg_nxt = h_region(h_nxt);
    v_reg_nxt = v_region(v_nxt);
    hsync_nxt = (h_reg_nxt == REG_SYNC) ? SYNC_ON : SYNC_OFF;
    vsync_nxt = (v_reg_nxt == REG_SYNC) ? SYNC_ON : SYNC_OFF;
    blank_nxt = (h_reg_nxt != REG_ACTIVE) || (v_reg_nxt != REG_ACTIVE);
  end

  // Output and state registers; reset wins over en and never emits a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      blank       <= 1'b0;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      blank       <= blank_nxt;
      pix_en      <= tick;
      line_start  <= tick && h_wrap;
      frame_start <= tick && h_wrap && v_wrap;
    end
  end

endmodule
